// File: rtl/i2s_pkg.sv
// Constants and sample type shared by the I2S TX serializer and the RX deserializer.
package i2s_pkg;

    localparam int FRAME_BITS = 32;
    localparam int SLOT_BITS  = 16;

    typedef logic [SLOT_BITS-1:0] sample_t;

endpackage

// File: rtl/i2s_tx_holdreg.sv
// Sample holding register with fresh/primed tracking and overrun/underrun pulses.
// Frame value is combinational on load_i; status pulses are registered (one clock later).
module i2s_tx_holdreg
    import i2s_pkg::*;
#(
    parameter int PKT_WIDTH = SLOT_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 load_i,
    input  logic [PKT_WIDTH-1:0] pkt_i,
    input  logic                 pkt_vld_i,
    output logic [PKT_WIDTH-1:0] sample_o,
    output logic                 underrun_o,
    output logic                 overrun_o
);

    logic [PKT_WIDTH-1:0] hold_q, hold_d;
    logic                 fresh_q, fresh_d;
    logic                 primed_q, primed_d;
    logic                 underrun_q, underrun_d;
    logic                 overrun_q, overrun_d;

    always_comb begin
        hold_d     = hold_q;
        fresh_d    = fresh_q;
        primed_d   = primed_q;
        underrun_d = 1'b0;
        overrun_d  = 1'b0;

        if (pkt_vld_i) begin
            hold_d   = pkt_i;
            primed_d = 1'b1;
        end

        // A strobe coinciding with a load is consumed by that load, so fresh stays clear.
        if (load_i) begin
            fresh_d    = 1'b0;
            underrun_d = !pkt_vld_i && !fresh_q && primed_q;
        end else if (pkt_vld_i) begin
            fresh_d   = 1'b1;
            overrun_d = fresh_q;
        end
    end

    assign sample_o = (load_i && pkt_vld_i) ? pkt_i : hold_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_q     <= '0;
            fresh_q    <= 1'b0;
            primed_q   <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            fresh_q    <= fresh_d;
            primed_q   <= primed_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    assign underrun_o = underrun_q;
    assign overrun_o  = overrun_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: frames the held mono sample into both slots, MSB first, with ws leading by one bit.
// A sample accepted in frame k starts on sd_o at bitCnt=0 of frame k+1; no backpressure, newest sample wins.
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int PKT_WIDTH  = SLOT_BITS,
    parameter int SLOT_WIDTH = SLOT_BITS
) (
    input  logic                 clkI2S,
    input  logic                 rstI2S_n,
    input  logic [PKT_WIDTH-1:0] pkt_i,
    input  logic                 pktChanged_i,
    input  logic                 mute_i,
    output logic                 ws_o,
    output logic                 sd_o,
    output logic                 frameStart_o,
    output logic                 underrun_o,
    output logic                 overrun_o
);

    localparam int FRAME_W = 2 * SLOT_WIDTH;
    localparam int CNT_W   = $clog2(FRAME_W);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] WS_RISE  = CNT_W'(SLOT_WIDTH - 1);

    logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
    logic [FRAME_W-1:0]    shift_q, shift_d;
    logic                  ws_q, ws_d;
    logic                  frameStart_q;
    logic                  load;
    logic [PKT_WIDTH-1:0]  sample;
    logic [SLOT_WIDTH-1:0] slot;

    assign load = (bitCnt_q == CNT_LAST);

    i2s_tx_holdreg #(
        .PKT_WIDTH (PKT_WIDTH)
    ) u_holdreg (
        .clk_i      (clkI2S),
        .rst_n_i    (rstI2S_n),
        .load_i     (load),
        .pkt_i      (pkt_i),
        .pkt_vld_i  (pktChanged_i),
        .sample_o   (sample),
        .underrun_o (underrun_o),
        .overrun_o  (overrun_o)
    );

    // Left-justify into the slot: pad LSBs with zero or keep only the MSBs.
    generate
        if (PKT_WIDTH >= SLOT_WIDTH) begin : g_trunc
            assign slot = sample[PKT_WIDTH-1 -: SLOT_WIDTH];
        end else begin : g_pad
            assign slot = {sample, {(SLOT_WIDTH - PKT_WIDTH){1'b0}}};
        end
    endgenerate

    always_comb begin
        bitCnt_d = load ? '0 : bitCnt_q + 1'b1;
        shift_d  = {shift_q[FRAME_W-2:0], 1'b0};
        if (load) begin
            shift_d = mute_i ? '0 : {slot, slot};
        end
        // ws flips one bit-clock before each slot's MSB.
        ws_d = (bitCnt_d >= WS_RISE) && (bitCnt_d != CNT_LAST);
    end

    always_ff @(posedge clkI2S or negedge rstI2S_n) begin
        if (!rstI2S_n) begin
            bitCnt_q     <= CNT_LAST;
            shift_q      <= '0;
            ws_q         <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            bitCnt_q     <= bitCnt_d;
            shift_q      <= shift_d;
            ws_q         <= ws_d;
            frameStart_q <= load;
        end
    end

    assign sd_o         = shift_q[FRAME_W-1];
    assign ws_o         = ws_q;
    assign frameStart_o = frameStart_q;

endmodule
